// File: rtl/sync_fifo_flags_pkg.sv
// rtl/sync_fifo_flags_pkg.sv - shared mode constants and pointer-width helper
package sync_fifo_flags_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// rtl/sync_fifo_flags_mem.sv - DEPTH x DATA_W dual-port array, sync write, async read
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with level flags, sticky errors, optional FWFT
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = FWFT_OFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    r_en,
    output logic [DATA_W-1:0]       data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_THRESH < 1 || AF_THRESH > DEPTH ||
        AE_THRESH < 0 || AE_THRESH > DEPTH - 1 ||
        (FWFT != FWFT_OFF && FWFT != FWFT_ON)) begin : g_bad_param
        $error("sync_fifo_flags: illegal parameter set");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d, rd_data;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              rd_acc, wr_acc;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign rd_acc = r_en & ~empty;
    assign wr_acc = w_en & (~full | rd_acc);

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q),
        .wdata_i (data_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        dout_d = dout_q;
        if (FWFT == FWFT_OFF && rd_acc) dout_d = rd_data;
        ovf_d = (w_en & ~wr_acc) | (ovf_q & ~clr_err);
        unf_d = (r_en & ~rd_acc) | (unf_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = (FWFT == FWFT_ON) ? (empty ? '0 : rd_data) : dout_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - randomized and directed bench with queue reference model
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ws = 0, rs = 0, cs = 0, wf = 0, rf = 0, cf = 0;
    logic [7:0] ds = 0, df = 0;
    logic [7:0] s_dout, f_dout;
    logic [2:0] s_cnt, f_cnt;
    logic s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    sync_fifo_flags #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .w_en(ws), .data_in(ds), .r_en(rs), .data_out(s_dout),
        .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .count(s_cnt), .overflow(s_ovf), .underflow(s_unf), .clr_err(cs)
    );

    sync_fifo_flags #(.DATA_W(8), .DEPTH(4), .AF_THRESH(4), .AE_THRESH(0), .FWFT(1)) u_fw (
        .clk(clk), .rst(rst), .w_en(wf), .data_in(df), .r_en(rf), .data_out(f_dout),
        .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_cnt), .overflow(f_ovf), .underflow(f_unf), .clr_err(cf)
    );

    logic [7:0] qs[$], qf[$];
    logic [7:0] ms_dout = 0;
    bit ms_ovf = 0, ms_unf = 0, mf_ovf = 0, mf_unf = 0;
    int n_checks = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        qs.delete(); qf.delete();
        ms_dout = 0; ms_ovf = 0; ms_unf = 0; mf_ovf = 0; mf_unf = 0;
    endtask

    // Queue-level reference: a pop needs a stored word, a push needs room or a same-cycle pop.
    task automatic model_update();
        bit rd, wr;
        rd = rs && qs.size() > 0;
        wr = ws && (qs.size() < 4 || rd);
        ms_ovf = (ws && !wr) || (ms_ovf && !cs);
        ms_unf = (rs && !rd) || (ms_unf && !cs);
        if (rd) ms_dout = qs.pop_front();
        if (wr) qs.push_back(ds);
        rd = rf && qf.size() > 0;
        wr = wf && (qf.size() < 4 || rd);
        mf_ovf = (wf && !wr) || (mf_ovf && !cf);
        mf_unf = (rf && !rd) || (mf_unf && !cf);
        if (rd) void'(qf.pop_front());
        if (wr) qf.push_back(df);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_update();
        @(negedge clk);
    endtask

    task automatic wr_s(input logic [7:0] d);
        ws = 1; ds = d; tick(); ws = 0;
    endtask

    task automatic rd_s();
        rs = 1; tick(); rs = 0;
    endtask

    always @(negedge clk) begin
        chk("std.count", s_cnt, qs.size());
        chk("std.full", s_full, qs.size() == 4);
        chk("std.empty", s_empty, qs.size() == 0);
        chk("std.almost_full", s_af, qs.size() >= 3);
        chk("std.almost_empty", s_ae, qs.size() <= 1);
        chk("std.overflow", s_ovf, ms_ovf);
        chk("std.underflow", s_unf, ms_unf);
        chk("std.data_out", s_dout, ms_dout);
        chk("fwft.count", f_cnt, qf.size());
        chk("fwft.full", f_full, qf.size() == 4);
        chk("fwft.empty", f_empty, qf.size() == 0);
        chk("fwft.almost_full", f_af, qf.size() >= 4);
        chk("fwft.almost_empty", f_ae, qf.size() == 0);
        chk("fwft.overflow", f_ovf, mf_ovf);
        chk("fwft.underflow", f_unf, mf_unf);
        if (qf.size() > 0) chk("fwft.data_out", f_dout, qf[0]);
    end

    logic [7:0] v1 [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    initial begin
        @(negedge clk); @(negedge clk);
        chk("rst.count", s_cnt, 0);
        chk("rst.empty", s_empty, 1);
        chk("rst.full", s_full, 0);
        chk("rst.almost_empty", s_ae, 1);
        chk("rst.almost_full", s_af, 0);
        chk("rst.data_out", s_dout, 0);
        chk("rst.flags", {s_ovf, s_unf}, 0);
        rst = 0;

        for (int i = 0; i < 4; i++) wr_s(v1[i]);
        chk("t1.full", s_full, 1);
        chk("t1.count", s_cnt, 4);
        chk("t1.almost_full", s_af, 1);
        for (int i = 0; i < 4; i++) begin
            rd_s();
            chk("t1.read", s_dout, v1[i]);
        end
        chk("t1.empty", s_empty, 1);

        for (int i = 0; i < 4; i++) wr_s(8'(i + 1));
        ws = 1; ds = 8'hEE; tick(); ws = 0;
        chk("t2.overflow", s_ovf, 1);
        chk("t2.count", s_cnt, 4);
        cs = 1; tick(); cs = 0;
        chk("t2.clr", s_ovf, 0);
        for (int i = 0; i < 4; i++) begin
            rd_s();
            chk("t2.read", s_dout, i + 1);
        end

        rd_s();
        chk("t3.underflow", s_unf, 1);
        chk("t3.hold", s_dout, 4);
        chk("t3.count", s_cnt, 0);
        ws = 1; ds = 8'h55; rs = 1; tick(); ws = 0; rs = 0;
        chk("t3.count1", s_cnt, 1);
        rd_s();
        chk("t3.read", s_dout, 8'h55);
        cs = 1; tick(); cs = 0;

        for (int i = 0; i < 4; i++) wr_s(8'(8'h10 + i));
        for (int i = 0; i < 8; i++) begin
            ws = 1; rs = 1; ds = 8'(8'h20 + i); tick();
            chk("t4.count", s_cnt, 4);
            chk("t4.full", s_full, 1);
            chk("t4.read", s_dout, (i < 4) ? 8'h10 + i : 8'h20 + i - 4);
        end
        ws = 0; rs = 0;
        for (int i = 0; i < 4; i++) begin
            rd_s();
            chk("t4.drain", s_dout, 8'h24 + i);
        end

        wf = 1; df = 8'h11; tick(); wf = 0;
        chk("t5.fall", f_dout, 8'h11);
        wf = 1; df = 8'h22; tick(); wf = 0;
        chk("t5.head", f_dout, 8'h11);
        rf = 1; tick(); rf = 0;
        chk("t5.pop", f_dout, 8'h22);
        rf = 1; tick(); rf = 0;
        chk("t5.empty", f_empty, 1);

        for (int i = 0; i < 3; i++) wr_s(8'(8'h30 + i));
        #2 rst = 1;
        model_reset();
        #1;
        chk("t6.count", s_cnt, 0);
        chk("t6.empty", s_empty, 1);
        chk("t6.full", s_full, 0);
        chk("t6.almost_empty", s_ae, 1);
        chk("t6.almost_full", s_af, 0);
        chk("t6.data_out", s_dout, 0);
        @(negedge clk);
        rst = 0;
        wr_s(8'h77);
        rd_s();
        chk("t6.read", s_dout, 8'h77);

        for (int i = 0; i < 2000; i++) begin
            bit heavy;
            heavy = (i % 200) < 100;
            ws = heavy ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rs = heavy ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            wf = heavy ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            rf = heavy ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            cs = ($urandom_range(15) == 0);
            cf = ($urandom_range(15) == 0);
            ds = 8'($urandom);
            df = 8'($urandom);
            tick();
        end
        ws = 0; rs = 0; wf = 0; rf = 0; cs = 0; cf = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
